// File: rtl/vault_port_arbiter.sv
// Round-robin front end for the BitVault register file: NREQ requesters share its single
// write/read port, with one transaction in flight from accept through completion.
module vault_port_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 2,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_rdata,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               vault_we,
  output logic [AW-1:0]      vault_waddr,
  output logic [DW-1:0]      vault_wdata,
  output logic [AW-1:0]      vault_raddr,
  input  logic [DW-1:0]      vault_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]    state;
  logic [1:0]    last_grant;
  logic          win_found;
  logic [1:0]    win_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          owner_ready;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  // Priority scan starts just past the previous winner and wraps around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && req_valid[i] && (((int'(last_grant) + k) % NREQ) == i)) begin
          win_found = 1'b1;
          win_id    = 2'(i);
        end
      end
    end
  end

  always_comb begin
    sel_we      = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    req_ready   = '0;
    rsp_valid   = '0;
    owner_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 2'(i)) begin
        sel_we       = req_we[i];
        sel_addr     = req_addr[i*AW +: AW];
        sel_wdata    = req_wdata[i*DW +: DW];
        req_ready[i] = rst_n && (state == IDLE) && win_found;
      end
      if (grant_id == 2'(i)) begin
        rsp_valid[i] = (state == RESP);
        owner_ready  = rsp_ready[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 2'(NREQ - 1);
      grant_id   <= '0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            last_grant <= win_id;
            grant_id   <= win_id;
            state      <= ISSUE;
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          rsp_rdata <= we_q ? '0 : vault_rdata;
          state     <= RESP;
        end
        RESP: begin
          if (owner_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Transaction fields are only observed outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && win_found) begin
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  assign busy        = (state != IDLE);
  assign vault_we    = (state == ISSUE) && we_q;
  assign vault_waddr = (state == ISSUE) ? addr_q : '0;
  assign vault_wdata = (state == ISSUE) ? wdata_q : '0;
  assign vault_raddr = (state == ISSUE || state == CAPTURE) ? addr_q : '0;

endmodule

// File: doc/vault_port_arbiter.md
# vault_port_arbiter

Round-robin controller that shares the single write/read port of the 4x8 BitVault register file between NREQ independent requesters. Each requester issues read or write transactions over a valid/ready request channel and receives a completion on a valid/ready response channel. The block sits directly in front of the register file: it owns every BitVault control input and samples BitVault read data. Exactly one transaction is in flight at a time.

## Interface
- NREQ, 2: number of requesters, legal 2..4
- AW, 2: register-file address width
- DW, 8: register-file data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester request accepted (one-hot or zero)
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
- rsp_valid  out  NREQ  completion valid, one-hot to the owning requester
- rsp_ready  in  NREQ  completion accepted
- rsp_rdata  out  DW  read data (0 for write completions)
- grant_id  out  2  index of current/last owner
- busy  out  1  high in any state other than IDLE
- vault_we  out  1  BitVault write enable
- vault_waddr  out  AW  BitVault write address
- vault_wdata  out  DW  BitVault write data
- vault_raddr  out  AW  BitVault read address
- vault_rdata  in  DW  BitVault read data

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any req_valid, winner = first set bit scanning from (last_grant+1) mod NREQ upward with wrap. req_ready[winner] is high combinationally in IDLE only. On the clock edge: latch we/addr/wdata/id, set last_grant = winner, go to ISSUE.
- ISSUE: one cycle. Drive vault_waddr and vault_raddr = latched addr. Drive vault_wdata = latched wdata. Drive vault_we = latched we. Go to CAPTURE.
- CAPTURE: one cycle. vault_we = 0, vault_raddr held. At the end of the cycle, register rsp_rdata = vault_rdata for reads, 0 for writes. Go to RESP.
- RESP: rsp_valid[id] = 1, rsp_rdata stable. When rsp_ready[id] is high, go to IDLE. A new request cannot be accepted in that same cycle.
- Requests are ignored while busy. req_ready is 0 outside IDLE. Requesters must hold request fields stable until accepted.
- rsp_ready bits of non-owning requesters are ignored.
- vault_we is high only in ISSUE of a write, for exactly one cycle per write. It is never high for reads.
- Reset, asynchronous and effective at any state:
  - state = IDLE, last_grant = NREQ-1 (so requester 0 has priority first).
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, grant_id, busy, vault_*.
  - An in-flight transaction is dropped with no completion. Any vault write already issued stays in BitVault.

## Timing
- Accept at edge E0 (IDLE, valid & ready).
- Vault write or read address presented during cycle E0..E1 (ISSUE).
- Write lands in BitVault at E1.
- Read data sampled at E2. rsp_valid asserted from E2 onward.
- Minimum 4 cycles per transaction (accept, ISSUE, CAPTURE, RESP with rsp_ready=1). Back-to-back accepts are 4 edges apart.
- A read issued immediately after a write to the same address returns the new value. BitVault commits the write before the read's CAPTURE cycle.
- grant_id updates at the accept edge and holds until the next accept.

## Test plan
- Reset mid-RESP, asserted while rsp_valid=1 for requester 1 -> all outputs 0 asynchronously. After release, simultaneous requests from 0 and 1 -> requester 0 granted first.
- Requester 0 writes addr 2 data 0xA5, then reads addr 2 -> vault_we high exactly 1 cycle with waddr=2, wdata=0xA5. Read completion carries rsp_rdata=0xA5. Write completion carries rsp_rdata=0.
- Both requesters hold req_valid continuously, with reads to addr 0 and addr 3 -> grants alternate 0,1,0,1. Each completion goes to the correct one-hot rsp_valid bit. Accepts are 4 cycles apart.
- Requester 1 read with rsp_ready held low 5 cycles -> rsp_valid[1] and rsp_rdata stay stable, req_ready stays 0, and requester 0's pending request is not accepted until 1 cycle after rsp_ready[1] rises.
- NREQ=3, requester 2 granted last, then requesters 0 and 1 request together -> requester 0 wins (wrap-around).
- Read of a never-written address after reset -> rsp_rdata=0, vault_we never asserted throughout.
